// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline: IF/ID control codes,
// the NOP word and the fetch-stage state encoding.
package mips_pipe_pkg;

  localparam logic [1:0]  IF_ADVANCE = 2'b00;
  localparam logic [1:0]  IF_HOLD    = 2'b01;
  localparam logic [1:0]  IF_FLUSH   = 2'b10;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    DRAIN
  } if_state_t;

  // Redirect targets come from branch arithmetic and may carry junk low bits.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/ready bus between the fetch stage (master)
// and the instruction memory (slave).
interface if_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats hold beats advance; an advance
// without a usable fetch inserts a bubble.
module if_id_reg
  import mips_pipe_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  i_ctrl,
  input  logic        i_load,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pc_plus4,
  input  logic [31:0] i_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_instr,
  output logic        o_valid
);

  logic [31:0] r_pc;
  logic [31:0] r_pc_plus4;
  logic [31:0] r_instr;
  logic        r_valid;

  // Any ctrl value with the upper bit set (10 or 11) is a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= 32'h0;
      r_pc_plus4 <= 32'h0;
      r_instr    <= NOP_INSTR;
      r_valid    <= 1'b0;
    end else if (i_ctrl[1]) begin
      r_pc       <= 32'h0;
      r_pc_plus4 <= 32'h0;
      r_instr    <= NOP_INSTR;
      r_valid    <= 1'b0;
    end else if (i_ctrl == IF_HOLD) begin
      r_pc       <= r_pc;
      r_pc_plus4 <= r_pc_plus4;
      r_instr    <= r_instr;
      r_valid    <= r_valid;
    end else if (i_load) begin
      r_pc       <= i_pc;
      r_pc_plus4 <= i_pc_plus4;
      r_instr    <= i_instr;
      r_valid    <= 1'b1;
    end else begin
      r_pc       <= 32'h0;
      r_pc_plus4 <= 32'h0;
      r_instr    <= NOP_INSTR;
      r_valid    <= 1'b0;
    end
  end

  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_instr    = r_instr;
  assign o_valid    = r_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, fetch FSM with redirect draining, and the
// IF/ID register driven by the hazard unit's stall/control commands.
module if_stage
  import mips_pipe_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_stall,
  input  logic [1:0]        if_ctrl,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_target,
  if_stage_if.master        imem,
  output logic [31:0]       id_pc,
  output logic [31:0]       id_pc_plus4,
  output logic [31:0]       id_instr,
  output logic              id_valid
);

  if_state_t   r_state;
  if_state_t   w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_pend_pc;
  logic [31:0] w_next_pc;
  logic [31:0] w_next_pend_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic        w_fetch_ok;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_target   = word_align(redirect_target);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= BOOT;
      r_pc      <= PC_RESET;
      r_pend_pc <= 32'h0;
    end else begin
      r_state   <= w_next_state;
      r_pc      <= w_next_pc;
      r_pend_pc <= w_next_pend_pc;
    end
  end

  // A redirect that lands while a fetch is outstanding is parked in pend_pc
  // so imem_addr stays stable until the stale word comes back.
  always_comb begin
    w_next_state   = r_state;
    w_next_pc      = r_pc;
    w_next_pend_pc = r_pend_pc;
    w_fetch_ok     = 1'b0;
    unique case (r_state)
      BOOT: begin
        w_next_state = FETCH;
      end
      FETCH: begin
        if (redirect_valid && !imem.imem_ready) begin
          w_next_pend_pc = w_target;
          w_next_state   = DRAIN;
        end else if (redirect_valid) begin
          w_next_pc = w_target;
        end else if (pc_stall || !imem.imem_ready) begin
          w_next_pc = r_pc;
        end else begin
          w_next_pc  = w_pc_plus4;
          w_fetch_ok = 1'b1;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          w_next_pend_pc = w_target;
        end
        if (imem.imem_ready) begin
          w_next_pc    = redirect_valid ? w_target : r_pend_pc;
          w_next_state = FETCH;
        end
      end
      default: begin
        w_next_state = BOOT;
      end
    endcase
  end

  assign imem.imem_req  = (r_state != BOOT);
  assign imem.imem_addr = r_pc;

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .i_ctrl     (if_ctrl),
    .i_load     (w_fetch_ok),
    .i_pc       (r_pc),
    .i_pc_plus4 (w_pc_plus4),
    .i_instr    (imem.imem_rdata),
    .o_pc       (id_pc),
    .o_pc_plus4 (id_pc_plus4),
    .o_instr    (id_instr),
    .o_valid    (id_valid)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a vector table for the main fetch flow plus
// hand sequences for async reset mid-DRAIN and PC wrap-around.
module tb_if_stage;
  import mips_pipe_pkg::*;

  typedef struct {
    logic        stall;
    logic [1:0]  ctrl;
    logic        rv;
    logic [31:0] target;
    logic        ready;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expPc;
    logic [31:0] expInstr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pcStall = 1'b0;
  logic [1:0]  ifCtrl = 2'b00;
  logic        redirectValid = 1'b0;
  logic [31:0] redirectTarget = 32'h0;
  logic [31:0] idPc, idPcPlus4, idInstr;
  logic        idValid;
  logic [31:0] idPc2, idPcPlus42, idInstr2;
  logic        idValid2;

  int compareCount = 0;
  int failCount    = 0;

  if_stage_if imemBus ();
  if_stage_if imemBus2 ();

  // Memory model: instruction word equals the word index of its address.
  assign imemBus.imem_rdata  = imemBus.imem_addr >> 2;
  assign imemBus2.imem_rdata = imemBus2.imem_addr >> 2;
  assign imemBus2.imem_ready = 1'b1;

  always #5 clk = ~clk;

  if_stage dut (
    .clk             (clk),
    .rst             (rst),
    .pc_stall        (pcStall),
    .if_ctrl         (ifCtrl),
    .redirect_valid  (redirectValid),
    .redirect_target (redirectTarget),
    .imem            (imemBus.master),
    .id_pc           (idPc),
    .id_pc_plus4     (idPcPlus4),
    .id_instr        (idInstr),
    .id_valid        (idValid)
  );

  if_stage #(
    .PC_RESET (32'hFFFF_FFF8)
  ) dutWrap (
    .clk             (clk),
    .rst             (rst),
    .pc_stall        (1'b0),
    .if_ctrl         (2'b00),
    .redirect_valid  (1'b0),
    .redirect_target (32'h0),
    .imem            (imemBus2.master),
    .id_pc           (idPc2),
    .id_pc_plus4     (idPcPlus42),
    .id_instr        (idInstr2),
    .id_valid        (idValid2)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compareCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    pcStall                = v.stall;
    ifCtrl                 = v.ctrl;
    redirectValid          = v.rv;
    redirectTarget         = v.target;
    imemBus.imem_ready     = v.ready;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".req"},    {31'h0, imemBus.imem_req}, 32'h0);
    checkOutput({tag, ".addr"},   imemBus.imem_addr, 32'h0);
    checkOutput({tag, ".valid"},  {31'h0, idValid}, 32'h0);
    checkOutput({tag, ".pc"},     idPc, 32'h0);
    checkOutput({tag, ".pc4"},    idPcPlus4, 32'h0);
    checkOutput({tag, ".instr"},  idInstr, NOP);
    checkOutput({tag, ".state"},  {30'h0, dut.r_state}, {30'h0, BOOT});
    checkOutput({tag, ".pend"},   dut.r_pend_pc, 32'h0);
    checkOutput({tag, ".wrapAddr"}, imemBus2.imem_addr, 32'hFFFF_FFF8);
  endtask

  vec_t vecs[$];

  // Fields: stall, ctrl, rv, target, ready | req, addr, valid, id_pc, id_instr
  initial begin
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b0, 32'h0,   32'h0});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b1, 32'h0,   32'h0});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   1'b1, 32'h4,   32'h1});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   1'b1, 32'h8,   32'h2});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  1'b1, 32'hC,   32'h3});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  1'b1, 32'hC,   32'h3});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  1'b1, 32'hC,   32'h3});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  1'b1, 32'hC,   32'h3});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0,   1'b1, 1'b1, 32'h14,  1'b1, 32'h10,  32'h4});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0,   1'b1, 1'b1, 32'h18,  1'b1, 32'h14,  32'h5});
    vecs.push_back('{1'b0, 2'b10, 1'b1, 32'h400, 1'b1, 1'b1, 32'h400, 1'b0, 32'h0,   32'h0});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0,   1'b1, 1'b1, 32'h404, 1'b1, 32'h400, 32'h100});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h203, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   32'h0});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0,   1'b1, 1'b1, 32'h204, 1'b1, 32'h200, 32'h80});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h83,  1'b0, 1'b1, 32'h204, 1'b0, 32'h0,   32'h0});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0,   1'b0, 1'b1, 32'h204, 1'b0, 32'h0,   32'h0});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h0,   1'b1, 1'b1, 32'h80,  1'b0, 32'h0,   32'h0});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0,   1'b1, 1'b1, 32'h84,  1'b1, 32'h80,  32'h20});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h0,   1'b1, 1'b1, 32'h84,  1'b0, 32'h0,   32'h0});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0,   1'b1, 1'b1, 32'h88,  1'b1, 32'h84,  32'h21});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0,   1'b0, 1'b1, 32'h88,  1'b0, 32'h0,   32'h0});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8C,  1'b1, 32'h88,  32'h22});
    vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h0,   1'b1, 1'b1, 32'h90,  1'b1, 32'h88,  32'h22});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h300, 1'b0, 1'b1, 32'h90,  1'b0, 32'h0,   32'h0});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h500, 1'b0, 1'b1, 32'h90,  1'b0, 32'h0,   32'h0});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0,   1'b1, 1'b1, 32'h500, 1'b0, 32'h0,   32'h0});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0,   1'b1, 1'b1, 32'h504, 1'b1, 32'h500, 32'h140});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h0,   1'b1, 1'b1, 32'h504, 1'b0, 32'h0,   32'h0});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0,   1'b1, 1'b1, 32'h508, 1'b1, 32'h504, 32'h141});
    vecs.push_back('{1'b0, 2'b11, 1'b0, 32'h0,   1'b1, 1'b1, 32'h50C, 1'b0, 32'h0,   32'h0});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0,   1'b1, 1'b1, 32'h510, 1'b1, 32'h50C, 32'h143});

    imemBus.imem_ready = 1'b1;
    #1 rst = 1'b1;
    #2;
    checkResetState("reset");
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d.req", i),   {31'h0, imemBus.imem_req}, {31'h0, vecs[i].expReq});
      checkOutput($sformatf("v%0d.addr", i),  imemBus.imem_addr, vecs[i].expAddr);
      checkOutput($sformatf("v%0d.valid", i), {31'h0, idValid}, {31'h0, vecs[i].expValid});
      checkOutput($sformatf("v%0d.pc", i),    idPc, vecs[i].expPc);
      checkOutput($sformatf("v%0d.pc4", i),   idPcPlus4,
                  vecs[i].expValid ? vecs[i].expPc + 32'd4 : 32'h0);
      checkOutput($sformatf("v%0d.instr", i), idInstr, vecs[i].expInstr);
      @(negedge clk);
    end

    // Enter DRAIN with a pending redirect, then hit reset between edges.
    applyStimulus('{1'b0, 2'b00, 1'b1, 32'h600, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0});
    @(posedge clk);
    #1;
    checkOutput("drain.state", {30'h0, dut.r_state}, {30'h0, DRAIN});
    checkOutput("drain.addr",  imemBus.imem_addr, 32'h510);
    checkOutput("drain.req",   {31'h0, imemBus.imem_req}, 32'h1);
    #2 rst = 1'b1;
    #1;
    checkResetState("asyncReset");

    @(negedge clk);
    applyStimulus('{1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0});
    rst = 1'b0;

    @(posedge clk);
    #1;
    checkOutput("post1.addr",     imemBus.imem_addr, 32'h0);
    checkOutput("post1.valid",    {31'h0, idValid}, 32'h0);
    checkOutput("post1.wrapAddr", imemBus2.imem_addr, 32'hFFFF_FFF8);
    @(posedge clk);
    #1;
    checkOutput("post2.valid",    {31'h0, idValid}, 32'h1);
    checkOutput("post2.instr",    idInstr, 32'h0);
    checkOutput("post2.wrapAddr", imemBus2.imem_addr, 32'hFFFF_FFFC);
    checkOutput("post2.wrapPc",   idPc2, 32'hFFFF_FFF8);
    @(posedge clk);
    #1;
    checkOutput("post3.pc",       idPc, 32'h4);
    checkOutput("post3.instr",    idInstr, 32'h1);
    checkOutput("post3.wrapAddr", imemBus2.imem_addr, 32'h0);
    checkOutput("post3.wrapPc",   idPc2, 32'hFFFF_FFFC);
    checkOutput("post3.wrapPc4",  idPcPlus42, 32'h0);
    checkOutput("post3.wrapInstr", idInstr2, 32'h3FFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline. Holds the PC and drives the instruction-memory request/ready handshake. Applies branch/jump redirects from MEM and presents the fetched instruction to ID. It consumes the hazard unit's PC-stall and IF-control outputs, so fetch halts and the IF/ID register holds or flushes exactly as the hazard unit commands.

## Interface
- PC_RESET, 32'h0000_0000, PC loaded on reset
- NOP_INSTR, 32'h0000_0000, instruction word inserted on bubble/flush
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high; clears all state immediately
- pc_stall  in  1  hazard unit: hold PC
- if_ctrl  in  2  hazard unit IF/ID control: 00 advance, 01 hold, 10 flush, 11 treated as flush
- redirect_valid  in  1  MEM-stage taken branch/jump
- redirect_target  in  32  new PC when redirect_valid
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (word-aligned)
- imem_ready  in  1  fetch complete this cycle; imem_rdata valid
- imem_rdata  in  32  instruction word
- id_pc, id_pc_plus4, id_instr  out  32 each  IF/ID register contents
- id_valid  out  1  IF/ID holds a real instruction

## Operation
- FSM states:
  - BOOT: imem_req=0. Entered by reset. Always goes to FETCH next cycle.
  - FETCH: imem_req=1, imem_addr=pc.
  - DRAIN: imem_req=1, imem_addr=pc. Waits out a stale in-flight fetch.
- FETCH behaviour, by priority:
  1. redirect_valid && !imem_ready: latch redirect_target into pend_pc, go DRAIN. PC and imem_addr stay unchanged while the request is outstanding.
  2. redirect_valid (with imem_ready): pc<=redirect_target; fetched word discarded.
  3. pc_stall: pc held; any fetched word discarded; the same address is refetched.
  4. !imem_ready: pc held.
  5. Otherwise: pc<=pc+4.
- DRAIN: on imem_ready, discard data, pc<=pend_pc, go FETCH.
  - A further redirect in DRAIN overwrites pend_pc; the last one wins.
  - pc_stall is ignored in DRAIN.
- IF/ID register, by priority:
  - flush (1x): id_instr=NOP_INSTR, id_valid=0, id_pc=id_pc_plus4=0.
  - hold (01): all fields unchanged.
  - advance (00):
    - Load {pc, pc+4, imem_rdata, 1} only if state=FETCH && imem_ready && !redirect_valid && !pc_stall.
    - Otherwise load a bubble (NOP_INSTR, valid 0, pc fields 0).
- Arithmetic: pc+4 is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC -> 0). The low two bits of redirect_target are forced to 0.
- Reset values: pc=PC_RESET, pend_pc=0, state=BOOT, imem_req=0, imem_addr=PC_RESET, id_pc=0, id_pc_plus4=0, id_instr=NOP_INSTR, id_valid=0.
- Reset mid-operation: the outstanding request is abandoned. Memory must tolerate imem_req dropping.

## Timing
- Fetch latency: the word returned with imem_ready in cycle N appears on id_instr/id_valid in cycle N+1.
- With single-cycle memory (imem_ready tied 1), sustained throughput is 1 instruction/cycle. The first valid ID instruction appears 2 cycles after reset release.
- Redirect with imem_ready=1 in cycle N: imem_addr=target in N+1. The first target instruction is valid in ID at N+2.
- imem_addr and imem_req are registered-state-only (no combinational path from inputs). They are stable while imem_req=1 && !imem_ready.
- Simultaneous pc_stall && if_ctrl=10 (branch vs data hazard): the hazard unit never emits this. If it occurs, flush wins for IF/ID and pc_stall wins for PC.

## Structure
- Shared package mips_pipe_pkg holds:
  - IF_ADVANCE=2'b00, IF_HOLD=2'b01, IF_FLUSH=2'b10
  - NOP constant
  - if_state_t enum {BOOT, FETCH, DRAIN}
- One sub-module, if_id_reg: the IF/ID register with advance/hold/flush/bubble, parameterised by NOP_INSTR.
- The FSM, PC and pend_pc logic live in if_stage.

## Test plan
- Reset then imem_ready=1, memory returns addr>>2: id_instr sequence 0,1,2,… starting 2 cycles after reset release; id_pc 0,4,8.
- pc_stall=1 with if_ctrl=01 for 3 cycles at pc=0x10: imem_addr stays 0x10 and the IF/ID register is frozen. After release the next id_pc is 0x10, with no skipped or duplicated instruction.
- redirect_valid=1, target 0x400, if_ctrl=10, imem_ready=1: id_valid=0 next cycle; imem_addr=0x400 next cycle; id_pc=0x400 one cycle later.
- imem_ready=0 for 2 cycles, redirect 0x80 arrives in the first: state DRAIN with imem_addr unchanged. When ready rises, the stale word is dropped (id_valid=0) and the next imem_addr is 0x80.
- PC_RESET=32'hFFFF_FFF8, imem_ready=1: imem_addr goes FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert rst asynchronously mid-DRAIN: all outputs take reset values before the next clock edge, and state is BOOT.
